// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU op
// codes, step encodings, instruction classes and the control-strobe bundle.
package cpu_ctrl_pkg;

   localparam int OPC_W   = 5;
   localparam int STATE_W = 5;

   // Instruction opcodes (IR[31:27])
   localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPC_W-1:0] OP_BRZR = 5'b10011;
   localparam logic [OPC_W-1:0] OP_BRNZ = 5'b10100;
   localparam logic [OPC_W-1:0] OP_BRPL = 5'b10101;
   localparam logic [OPC_W-1:0] OP_BRMI = 5'b10110;
   localparam logic [OPC_W-1:0] OP_MFHI = 5'b11000;
   localparam logic [OPC_W-1:0] OP_MFLO = 5'b11001;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

   // The ALU is driven with the R-type opcode of the operation it performs
   localparam logic [OPC_W-1:0] ALU_ADD = OP_ADD;
   localparam logic [OPC_W-1:0] ALU_AND = OP_AND;
   localparam logic [OPC_W-1:0] ALU_OR  = OP_OR;

   typedef enum logic [STATE_W-1:0] {
      ST_T0    = 5'd0,
      ST_T1    = 5'd1,
      ST_T2    = 5'd2,
      ST_T3    = 5'd3,
      ST_T4    = 5'd4,
      ST_T5    = 5'd5,
      ST_T6    = 5'd6,
      ST_T7    = 5'd7,
      ST_HALT  = 5'd8,
      ST_FAULT = 5'd9
   } state_t;

   typedef enum logic [3:0] {
      CL_NONE, CL_ALU, CL_MULDIV, CL_IMM, CL_LDI, CL_LD, CL_ST,
      CL_BR, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT, CL_ILLEGAL
   } cls_t;

   // Field order matches the port concatenation in the top module
   typedef struct packed {
      logic pc_sel, mdr_sel, zlo_sel, zhi_sel, hi_sel, lo_sel, c_sel, r_sel;
      logic pc_en, pc_inc, ir_en, y_en, z_en, mar_en, mdr_en, hi_en, lo_en,
            r_en, con_en;
      logic rd, wr, gra, grb, grc, baout;
   } ctrl_t;

   function automatic cls_t decode_class(input logic [OPC_W-1:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHL, OP_SHR, OP_ROL, OP_ROR:     decode_class = CL_ALU;
         OP_MUL, OP_DIV:                     decode_class = CL_MULDIV;
         OP_ADDI, OP_ANDI, OP_ORI:           decode_class = CL_IMM;
         OP_LDI:                             decode_class = CL_LDI;
         OP_LD:                              decode_class = CL_LD;
         OP_ST:                              decode_class = CL_ST;
         OP_BRZR, OP_BRNZ, OP_BRPL, OP_BRMI: decode_class = CL_BR;
         OP_MFHI:                            decode_class = CL_MFHI;
         OP_MFLO:                            decode_class = CL_MFLO;
         OP_NOP:                             decode_class = CL_NOP;
         OP_HALT:                            decode_class = CL_HALT;
         default:                            decode_class = CL_ILLEGAL;
      endcase
   endfunction

   // Immediate forms reuse the register-form ALU operation
   function automatic logic [OPC_W-1:0] alu_op_of(input logic [OPC_W-1:0] op);
      case (op)
         OP_ADDI: alu_op_of = ALU_ADD;
         OP_ANDI: alu_op_of = ALU_AND;
         OP_ORI:  alu_op_of = ALU_OR;
         default: alu_op_of = op;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting for mem_ready in a memory step and flags the
// last allowed cycle so the sequencer can fault instead of waiting forever.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic clear,
   input  logic active,
   input  logic ready,
   output logic timeout
);

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

   logic [CNT_W-1:0] count;

   // Restart on every entry to a wait step; saturate on the final cycle
   always_ff @(posedge clk) begin
      if (!clear || !active)
         count <= '0;
      else if (count != LAST)
         count <= count + CNT_W'(1);
   end

   assign timeout = active && !ready && (count == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2, class-specific execute T3-T7,
// memory handshake with timeout, run/halt and illegal-opcode faulting.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 5,
   parameter int MEM_TIMEOUT = 15,
   parameter int STEP_W      = 5
) (
   input  logic                clk,
   input  logic                clear,
   input  logic                run,
   input  logic [OPCODE_W-1:0] ir_opcode,
   input  logic                con_output,
   input  logic                mem_ready,
   output logic                PC_select,
   output logic                MDR_select,
   output logic                Z_LO_select,
   output logic                Z_HI_select,
   output logic                HI_select,
   output logic                LO_select,
   output logic                c_select,
   output logic                r_select,
   output logic                PC_enable,
   output logic                PC_increment_enable,
   output logic                IR_enable,
   output logic                Y_enable,
   output logic                Z_enable,
   output logic                MAR_enable,
   output logic                MDR_enable,
   output logic                HI_enable,
   output logic                LO_enable,
   output logic                r_enable,
   output logic                con_enable,
   output logic                read,
   output logic                write,
   output logic                Gra,
   output logic                Grb,
   output logic                Grc,
   output logic                BAout,
   output logic [OPCODE_W-1:0] alu_instruction,
   output logic                halted,
   output logic                fault,
   output logic [STEP_W-1:0]   step_state
);

   state_t              state, state_nxt;
   cls_t                cls, cls_nxt;
   logic [OPCODE_W-1:0] alu_q, alu_nxt;
   logic [OPCODE_W-1:0] alu_out;
   ctrl_t               ctrl, ctrl_o;
   logic                wait_active;
   logic                mem_timeout;

   // Steps that sit on the memory handshake
   assign wait_active = (state == ST_T1) ||
                        ((state == ST_T6) && (cls == CL_LD)) ||
                        ((state == ST_T7) && (cls == CL_ST));

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .clear   (clear),
      .active  (wait_active),
      .ready   (mem_ready),
      .timeout (mem_timeout)
   );

   // State, latched instruction class and ALU op
   always_ff @(posedge clk) begin
      if (!clear) begin
         state <= ST_T0;
         cls   <= CL_NONE;
         alu_q <= '0;
      end else begin
         state <= state_nxt;
         cls   <= cls_nxt;
         alu_q <= alu_nxt;
      end
   end

   // Next-step and strobe decode
   always_comb begin
      state_nxt = state;
      cls_nxt   = cls;
      alu_nxt   = alu_q;
      ctrl      = '0;
      alu_out   = '0;
      case (state)
         ST_T0: begin
            if (run) begin
               ctrl.pc_sel = 1'b1;
               ctrl.mar_en = 1'b1;
               state_nxt   = ST_T1;
            end
         end
         ST_T1: begin
            ctrl.rd     = 1'b1;
            ctrl.mdr_en = 1'b1;
            if (mem_ready) begin
               ctrl.pc_inc = 1'b1;
               state_nxt   = ST_T2;
            end else if (mem_timeout) begin
               state_nxt = ST_FAULT;
            end
         end
         ST_T2: begin
            ctrl.mdr_sel = 1'b1;
            ctrl.ir_en   = 1'b1;
            state_nxt    = ST_T3;
         end
         ST_T3: begin
            cls_nxt   = decode_class(ir_opcode);
            alu_nxt   = alu_op_of(ir_opcode);
            state_nxt = ST_T4;
            case (cls_nxt)
               CL_ALU, CL_IMM: begin
                  ctrl.grb = 1'b1; ctrl.r_sel = 1'b1; ctrl.y_en = 1'b1;
               end
               CL_MULDIV: begin
                  ctrl.gra = 1'b1; ctrl.r_sel = 1'b1; ctrl.y_en = 1'b1;
               end
               CL_LDI, CL_LD, CL_ST: begin
                  ctrl.grb = 1'b1; ctrl.baout = 1'b1; ctrl.y_en = 1'b1;
               end
               CL_BR: begin
                  ctrl.gra = 1'b1; ctrl.r_sel = 1'b1; ctrl.con_en = 1'b1;
               end
               CL_MFHI: begin
                  ctrl.hi_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_en = 1'b1;
                  state_nxt = ST_T0;
               end
               CL_MFLO: begin
                  ctrl.lo_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_en = 1'b1;
                  state_nxt = ST_T0;
               end
               CL_NOP:  state_nxt = ST_T0;
               CL_HALT: state_nxt = ST_HALT;
               default: state_nxt = ST_FAULT;
            endcase
         end
         ST_T4: begin
            state_nxt = ST_T5;
            case (cls)
               CL_ALU: begin
                  ctrl.grc = 1'b1; ctrl.r_sel = 1'b1; ctrl.z_en = 1'b1;
                  alu_out = alu_q;
               end
               CL_MULDIV: begin
                  ctrl.grb = 1'b1; ctrl.r_sel = 1'b1; ctrl.z_en = 1'b1;
                  alu_out = alu_q;
               end
               CL_IMM: begin
                  ctrl.c_sel = 1'b1; ctrl.z_en = 1'b1;
                  alu_out = alu_q;
               end
               CL_LDI, CL_LD, CL_ST: begin
                  ctrl.c_sel = 1'b1; ctrl.z_en = 1'b1;
                  alu_out = OPCODE_W'(ALU_ADD);
               end
               CL_BR: begin
                  ctrl.pc_sel = 1'b1; ctrl.y_en = 1'b1;
               end
               default: state_nxt = ST_FAULT;
            endcase
         end
         ST_T5: begin
            case (cls)
               CL_ALU, CL_IMM, CL_LDI: begin
                  ctrl.zlo_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_en = 1'b1;
                  state_nxt = ST_T0;
               end
               CL_MULDIV: begin
                  ctrl.zlo_sel = 1'b1; ctrl.lo_en = 1'b1;
                  state_nxt = ST_T6;
               end
               CL_LD, CL_ST: begin
                  ctrl.zlo_sel = 1'b1; ctrl.mar_en = 1'b1;
                  state_nxt = ST_T6;
               end
               CL_BR: begin
                  ctrl.c_sel = 1'b1; ctrl.z_en = 1'b1;
                  alu_out = OPCODE_W'(ALU_ADD);
                  state_nxt = ST_T6;
               end
               default: state_nxt = ST_FAULT;
            endcase
         end
         ST_T6: begin
            case (cls)
               CL_MULDIV: begin
                  ctrl.zhi_sel = 1'b1; ctrl.hi_en = 1'b1;
                  state_nxt = ST_T0;
               end
               CL_LD: begin
                  ctrl.rd = 1'b1; ctrl.mdr_en = 1'b1;
                  if (mem_ready)        state_nxt = ST_T7;
                  else if (mem_timeout) state_nxt = ST_FAULT;
               end
               CL_ST: begin
                  ctrl.gra = 1'b1; ctrl.r_sel = 1'b1; ctrl.mdr_en = 1'b1;
                  state_nxt = ST_T7;
               end
               CL_BR: begin
                  ctrl.zlo_sel = 1'b1;
                  ctrl.pc_en   = con_output;
                  state_nxt    = ST_T0;
               end
               default: state_nxt = ST_FAULT;
            endcase
         end
         ST_T7: begin
            case (cls)
               CL_LD: begin
                  ctrl.mdr_sel = 1'b1; ctrl.gra = 1'b1; ctrl.r_en = 1'b1;
                  state_nxt = ST_T0;
               end
               CL_ST: begin
                  ctrl.wr = 1'b1;
                  if (mem_ready)        state_nxt = ST_T0;
                  else if (mem_timeout) state_nxt = ST_FAULT;
               end
               default: state_nxt = ST_FAULT;
            endcase
         end
         ST_HALT:  state_nxt = ST_HALT;
         ST_FAULT: state_nxt = ST_FAULT;
         default:  state_nxt = ST_FAULT;
      endcase
   end

   // While clear is low nothing may fire, even from a mid-instruction step
   assign ctrl_o          = clear ? ctrl : '0;
   assign alu_instruction = clear ? alu_out : '0;
   assign halted          = clear && (state == ST_HALT);
   assign fault           = clear && (state == ST_FAULT);
   assign step_state      = clear ? STEP_W'(state) : '0;

   assign {PC_select, MDR_select, Z_LO_select, Z_HI_select, HI_select,
           LO_select, c_select, r_select,
           PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
           MAR_enable, MDR_enable, HI_enable, LO_enable, r_enable, con_enable,
           read, write, Gra, Grb, Grc, BAout} = ctrl_o;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks instruction classes step by
// step and compares every strobe against hand-written expectations.
module tb_control_sequencer;

   localparam logic [4:0] T0 = 5'd0, T1 = 5'd1, T2 = 5'd2, T3 = 5'd3;
   localparam logic [4:0] T4 = 5'd4, T5 = 5'd5, T6 = 5'd6, T7 = 5'd7;
   localparam logic [4:0] THALT = 5'd8, TFAULT = 5'd9;

   localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010;
   localparam logic [4:0] OP_ADD = 5'b00011, OP_AND = 5'b00101, OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_MUL = 5'b01111, OP_BRZR = 5'b10011, OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_NOP = 5'b11010, OP_HALT = 5'b11011, OP_UNDEF = 5'b11110;

   // Strobe bit positions in the observed vector
   localparam logic [24:0] S_PCS  = 25'd1 << 24, S_MDRS = 25'd1 << 23;
   localparam logic [24:0] S_ZLO  = 25'd1 << 22, S_ZHI  = 25'd1 << 21;
   localparam logic [24:0] S_HIS  = 25'd1 << 20, S_LOS  = 25'd1 << 19;
   localparam logic [24:0] S_CS   = 25'd1 << 18, S_RS   = 25'd1 << 17;
   localparam logic [24:0] E_PC   = 25'd1 << 16, E_PCI  = 25'd1 << 15;
   localparam logic [24:0] E_IR   = 25'd1 << 14, E_Y    = 25'd1 << 13;
   localparam logic [24:0] E_Z    = 25'd1 << 12, E_MAR  = 25'd1 << 11;
   localparam logic [24:0] E_MDR  = 25'd1 << 10, E_HI   = 25'd1 << 9;
   localparam logic [24:0] E_LO   = 25'd1 << 8,  E_R    = 25'd1 << 7;
   localparam logic [24:0] E_CON  = 25'd1 << 6,  M_RD   = 25'd1 << 5;
   localparam logic [24:0] M_WR   = 25'd1 << 4,  G_A    = 25'd1 << 3;
   localparam logic [24:0] G_B    = 25'd1 << 2,  G_C    = 25'd1 << 1;
   localparam logic [24:0] G_BA   = 25'd1;

   logic clk = 1'b0;
   logic clear, run, con_output, mem_ready;
   logic [4:0] ir_opcode;
   logic PC_select, MDR_select, Z_LO_select, Z_HI_select, HI_select, LO_select;
   logic c_select, r_select, PC_enable, PC_increment_enable, IR_enable;
   logic Y_enable, Z_enable, MAR_enable, MDR_enable, HI_enable, LO_enable;
   logic r_enable, con_enable, read, write, Gra, Grb, Grc, BAout;
   logic [4:0] alu_instruction;
   logic halted, fault;
   logic [4:0] step_state;

   int n_chk  = 0;
   int n_pass = 0;

   control_sequencer #(
      .OPCODE_W(5), .MEM_TIMEOUT(15), .STEP_W(5)
   ) dut (
      .clk(clk), .clear(clear), .run(run), .ir_opcode(ir_opcode),
      .con_output(con_output), .mem_ready(mem_ready),
      .PC_select(PC_select), .MDR_select(MDR_select), .Z_LO_select(Z_LO_select),
      .Z_HI_select(Z_HI_select), .HI_select(HI_select), .LO_select(LO_select),
      .c_select(c_select), .r_select(r_select), .PC_enable(PC_enable),
      .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
      .Y_enable(Y_enable), .Z_enable(Z_enable), .MAR_enable(MAR_enable),
      .MDR_enable(MDR_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
      .r_enable(r_enable), .con_enable(con_enable), .read(read), .write(write),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .BAout(BAout),
      .alu_instruction(alu_instruction), .halted(halted), .fault(fault),
      .step_state(step_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [24:0] strobes();
      return {PC_select, MDR_select, Z_LO_select, Z_HI_select, HI_select,
              LO_select, c_select, r_select,
              PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable,
              MAR_enable, MDR_enable, HI_enable, LO_enable, r_enable, con_enable,
              read, write, Gra, Grb, Grc, BAout};
   endfunction

   // Check one cycle, then move to just after the next rising edge
   task automatic step(input string tag, input logic [4:0] st,
                       input logic [24:0] s, input logic [4:0] alu);
      #1;
      chk({tag, ".state"},   32'(step_state), 32'(st));
      chk({tag, ".strobes"}, 32'(strobes()),  32'(s));
      chk({tag, ".alu"},     32'(alu_instruction), 32'(alu));
      chk({tag, ".hltflt"},  32'({halted, fault}),
          32'({st == THALT, st == TFAULT}));
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input string tag, input logic [4:0] op);
      ir_opcode = op;
      run       = 1'b1;
      mem_ready = 1'b1;
      step({tag, ".T0"}, T0, S_PCS | E_MAR, 5'd0);
      step({tag, ".T1"}, T1, M_RD | E_MDR | E_PCI, 5'd0);
      step({tag, ".T2"}, T2, S_MDRS | E_IR, 5'd0);
   endtask

   // Bus encoder must never see two selects at once
   always @(negedge clk)
      chk("onehot", 32'($countones({PC_select, MDR_select, Z_LO_select, Z_HI_select,
                                    HI_select, LO_select, c_select, r_select}) <= 1),
          32'd1);

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear = 1'b0; run = 1'b1; mem_ready = 1'b1; con_output = 1'b0; ir_opcode = OP_NOP;
      @(posedge clk);
      #1;
      step("rst0", T0, '0, 5'd0);
      step("rst1", T0, '0, 5'd0);
      clear = 1'b1;
      run   = 1'b0;
      step("idle0", T0, '0, 5'd0);
      step("idle1", T0, '0, 5'd0);

      // ldi: six cycles then back to T0
      fetch("ldi", OP_LDI);
      step("ldi.T3", T3, G_B | G_BA | E_Y, 5'd0);
      step("ldi.T4", T4, S_CS | E_Z, OP_ADD);
      step("ldi.T5", T5, S_ZLO | G_A | E_R, 5'd0);

      // mfhi: four cycles
      fetch("mfhi", OP_MFHI);
      step("mfhi.T3", T3, S_HIS | G_A | E_R, 5'd0);

      fetch("add", OP_ADD);
      step("add.T3", T3, G_B | S_RS | E_Y, 5'd0);
      step("add.T4", T4, G_C | S_RS | E_Z, OP_ADD);
      step("add.T5", T5, S_ZLO | G_A | E_R, 5'd0);

      fetch("mul", OP_MUL);
      step("mul.T3", T3, G_A | S_RS | E_Y, 5'd0);
      step("mul.T4", T4, G_B | S_RS | E_Z, OP_MUL);
      step("mul.T5", T5, S_ZLO | E_LO, 5'd0);
      step("mul.T6", T6, S_ZHI | E_HI, 5'd0);

      fetch("andi", OP_ANDI);
      step("andi.T3", T3, G_B | S_RS | E_Y, 5'd0);
      step("andi.T4", T4, S_CS | E_Z, OP_AND);
      step("andi.T5", T5, S_ZLO | G_A | E_R, 5'd0);

      // fetch with memory late by three cycles
      ir_opcode = OP_NOP;
      step("wait.T0", T0, S_PCS | E_MAR, 5'd0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) step("wait.T1", T1, M_RD | E_MDR, 5'd0);
      mem_ready = 1'b1;
      step("wait.T1rdy", T1, M_RD | E_MDR | E_PCI, 5'd0);
      step("wait.T2", T2, S_MDRS | E_IR, 5'd0);
      step("nop.T3", T3, '0, 5'd0);

      // branch not taken, then taken
      con_output = 1'b0;
      fetch("brn", OP_BRZR);
      step("brn.T3", T3, G_A | S_RS | E_CON, 5'd0);
      step("brn.T4", T4, S_PCS | E_Y, 5'd0);
      step("brn.T5", T5, S_CS | E_Z, OP_ADD);
      step("brn.T6", T6, S_ZLO, 5'd0);
      con_output = 1'b1;
      fetch("bry", OP_BRZR);
      step("bry.T3", T3, G_A | S_RS | E_CON, 5'd0);
      step("bry.T4", T4, S_PCS | E_Y, 5'd0);
      step("bry.T5", T5, S_CS | E_Z, OP_ADD);
      step("bry.T6", T6, S_ZLO | E_PC, 5'd0);
      con_output = 1'b0;

      // ld with one wait cycle at T6
      fetch("ld", OP_LD);
      step("ld.T3", T3, G_B | G_BA | E_Y, 5'd0);
      step("ld.T4", T4, S_CS | E_Z, OP_ADD);
      step("ld.T5", T5, S_ZLO | E_MAR, 5'd0);
      mem_ready = 1'b0;
      step("ld.T6w", T6, M_RD | E_MDR, 5'd0);
      mem_ready = 1'b1;
      step("ld.T6", T6, M_RD | E_MDR, 5'd0);
      step("ld.T7", T7, S_MDRS | G_A | E_R, 5'd0);

      // st holding write for two cycles
      fetch("st", OP_ST);
      step("st.T3", T3, G_B | G_BA | E_Y, 5'd0);
      step("st.T4", T4, S_CS | E_Z, OP_ADD);
      step("st.T5", T5, S_ZLO | E_MAR, 5'd0);
      step("st.T6", T6, G_A | S_RS | E_MDR, 5'd0);
      mem_ready = 1'b0;
      step("st.T7w0", T7, M_WR, 5'd0);
      step("st.T7w1", T7, M_WR, 5'd0);
      mem_ready = 1'b1;
      step("st.T7", T7, M_WR, 5'd0);

      // clear mid-ld at T6 aborts with nothing firing
      fetch("ldab", OP_LD);
      step("ldab.T3", T3, G_B | G_BA | E_Y, 5'd0);
      step("ldab.T4", T4, S_CS | E_Z, OP_ADD);
      step("ldab.T5", T5, S_ZLO | E_MAR, 5'd0);
      mem_ready = 1'b0;
      clear     = 1'b0;
      step("ldab.clr", T0, '0, 5'd0);
      clear = 1'b1;
      step("ldab.T0", T0, S_PCS | E_MAR, 5'd0);

      // undefined opcode faults and stays
      ir_opcode = OP_UNDEF;
      mem_ready = 1'b1;
      step("undef.T1", T1, M_RD | E_MDR | E_PCI, 5'd0);
      step("undef.T2", T2, S_MDRS | E_IR, 5'd0);
      step("undef.T3", T3, '0, 5'd0);
      step("undef.flt0", TFAULT, '0, 5'd0);
      step("undef.flt1", TFAULT, '0, 5'd0);
      clear = 1'b0;
      step("undef.clr", T0, '0, 5'd0);
      clear = 1'b1;

      // memory never answers during fetch: fault after 15 cycles in T1
      ir_opcode = OP_NOP;
      step("tmo.T0", T0, S_PCS | E_MAR, 5'd0);
      mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) step("tmo.T1", T1, M_RD | E_MDR, 5'd0);
      step("tmo.flt0", TFAULT, '0, 5'd0);
      mem_ready = 1'b1;
      step("tmo.flt1", TFAULT, '0, 5'd0);
      clear = 1'b0;
      step("tmo.clr", T0, '0, 5'd0);
      clear = 1'b1;

      // halt parks until clear
      fetch("halt", OP_HALT);
      step("halt.T3", T3, '0, 5'd0);
      step("halt.h0", THALT, '0, 5'd0);
      step("halt.h1", THALT, '0, 5'd0);
      clear = 1'b0;
      step("halt.clr", T0, '0, 5'd0);
      clear = 1'b1;
      step("halt.T0", T0, S_PCS | E_MAR, 5'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
